// File: rtl/key_pkg.sv
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types and helpers for the key press / buzzer
//                controller: press and beep FSM state encodings, the
//                millisecond-to-cycle conversion and the pressed key level.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_pkg;

    // Debounced key level that means "pressed" (key pulls the line low)
    localparam logic KEY_PRESSED = 1'b0;

    // Press classifier states
    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_HELD = 2'd1,
        P_LONG = 2'd2
    } press_state_t;

    // Buzzer pattern states
    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_ON   = 2'd1,
        B_GAP  = 2'd2
    } beep_state_t;

    // Number of clock cycles in a duration given in milliseconds.
    // Dividing first keeps the intermediate product inside 32 bits for
    // realistic clock frequencies.
    function automatic int ms_to_cyc(input int freq, input int ms);
        return (freq / 1000) * ms;
    endfunction

endpackage : key_pkg

`default_nettype wire

// File: rtl/beep_tone_gen.sv
// ============================================================================
//  Module      : beep_tone_gen
//  Description : Enable-gated half-period divider for a passive buzzer.
//                While i_en is high the output is a square wave that starts
//                high and toggles every TONE_HALF cycles; while i_en is low
//                the divider is held at phase 0 and the output is 0, so every
//                enable window begins with a fresh high half-period.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module beep_tone_gen #(
    parameter int TONE_HALF = 12500
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tone
);

    localparam int c_cnt_w = (TONE_HALF < 2) ? 1 : $clog2(TONE_HALF + 1);

    logic [c_cnt_w-1:0] r_half_cnt;
    logic               r_phase;

    // Half-period counter; phase flips each time a half period elapses
    always_ff @(posedge sys_clk) begin
        if (!rst_n || !i_en) begin
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (r_half_cnt == c_cnt_w'(TONE_HALF - 1)) begin
            r_half_cnt <= '0;
            r_phase    <= ~r_phase;
        end else begin
            r_half_cnt <= r_half_cnt + c_cnt_w'(1);
        end
    end

    // Phase 0 drives high so the first half-period of each window is audible
    assign o_tone = i_en & ~r_phase;

endmodule : beep_tone_gen

`default_nettype wire

// File: rtl/key_beep_ctrl.sv
// ============================================================================
//  Module      : key_beep_ctrl
//  Description : Consumes the debouncer's key_flag / key_value pair,
//                classifies each press as short or long, emits one-cycle
//                press-event pulses and plays a buzzer pattern: one beep for
//                a short press, two beeps separated by a gap for a long one.
//                Build option KEY_BEEP_TONE_EN: when defined the buzzer output
//                is a square wave (passive buzzer, beep_tone_gen divider);
//                when undefined it is a steady level (active buzzer).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_beep_ctrl
    import key_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int LONG_MS   = 1000,
    parameter int BEEP_MS   = 100,
    parameter int GAP_MS    = 100,
    parameter int TONE_HALF = 12500
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_flag,
    input  logic key_value,
    output logic short_press,
    output logic long_press,
    output logic beep,
    output logic beep_busy
);

    localparam int c_long_cyc = ms_to_cyc(CLK_FREQ, LONG_MS);
    localparam int c_beep_cyc = ms_to_cyc(CLK_FREQ, BEEP_MS);
    localparam int c_gap_cyc  = ms_to_cyc(CLK_FREQ, GAP_MS);
    localparam int c_max_bg   = (c_beep_cyc > c_gap_cyc) ? c_beep_cyc : c_gap_cyc;
    localparam int c_max_cyc  = (c_long_cyc > c_max_bg) ? c_long_cyc : c_max_bg;
    localparam int c_cnt_w    = $clog2(c_max_cyc + 1);

    // Elaboration-time sanity checks on the configuration
    if (TONE_HALF < 1) begin : g_bad_tone_half
        $error("key_beep_ctrl: TONE_HALF must be at least 1");
    end
    if (c_long_cyc < 2 || c_beep_cyc < 1 || c_gap_cyc < 1) begin : g_bad_timing
        $error("key_beep_ctrl: LONG/BEEP/GAP durations too short for CLK_FREQ");
    end

    // ------------------------------------------------------------------
    // Press classifier
    // ------------------------------------------------------------------
    press_state_t       r_pstate;
    press_state_t       w_pstate_nxt;
    logic [c_cnt_w-1:0] r_hold_cnt;
    logic [c_cnt_w-1:0] w_hold_nxt;
    logic               r_short;
    logic               r_long;
    logic               w_short_nxt;
    logic               w_long_nxt;
    logic               w_press_evt;
    logic               w_release_evt;

    assign w_press_evt   = key_flag & (key_value == KEY_PRESSED);
    assign w_release_evt = key_flag & (key_value != KEY_PRESSED);

    // Press FSM state, hold counter and registered event pulses
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_pstate   <= P_IDLE;
            r_hold_cnt <= '0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_pstate   <= w_pstate_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_short    <= w_short_nxt;
            r_long     <= w_long_nxt;
        end
    end

    // Press FSM next state. The hold count is the number of cycles since the
    // press flag (the flag cycle counts as 0, so the first held cycle reads
    // 1); hitting LONG_CYC-1 therefore puts long_press LONG_CYC cycles after
    // the press flag.
    always_comb begin
        w_pstate_nxt = r_pstate;
        w_hold_nxt   = r_hold_cnt;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        case (r_pstate)
            P_IDLE: begin
                w_hold_nxt = '0;
                if (w_press_evt) begin
                    w_pstate_nxt = P_HELD;
                    w_hold_nxt   = c_cnt_w'(1);
                end
            end
            P_HELD: begin
                if (r_hold_cnt == c_cnt_w'(c_long_cyc - 1)) begin
                    // Threshold wins over a simultaneous release; if the key
                    // was released on this very cycle there is no later
                    // release flag to wait for, so return straight to idle.
                    w_long_nxt   = 1'b1;
                    w_hold_nxt   = '0;
                    w_pstate_nxt = w_release_evt ? P_IDLE : P_LONG;
                end else if (w_release_evt) begin
                    w_short_nxt  = 1'b1;
                    w_hold_nxt   = '0;
                    w_pstate_nxt = P_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt + c_cnt_w'(1);
                end
            end
            P_LONG: begin
                w_hold_nxt = '0;
                if (w_release_evt) begin
                    w_pstate_nxt = P_IDLE;
                end
            end
            default: begin
                w_pstate_nxt = P_IDLE;
                w_hold_nxt   = '0;
            end
        endcase
    end

    assign short_press = r_short;
    assign long_press  = r_long;

    // ------------------------------------------------------------------
    // Beep pattern player
    // ------------------------------------------------------------------
    beep_state_t        r_bstate;
    beep_state_t        w_bstate_nxt;
    logic [c_cnt_w-1:0] r_btimer;
    logic [c_cnt_w-1:0] w_btimer_nxt;
    logic [1:0]         r_beeps_left;
    logic [1:0]         w_beeps_left_nxt;
    logic [1:0]         w_beeps_dec;
    logic               w_beep_on;

    assign w_beeps_dec = r_beeps_left - 2'd1;

    // Beep FSM state, phase timer and remaining-beep count
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_bstate     <= B_IDLE;
            r_btimer     <= '0;
            r_beeps_left <= 2'd0;
        end else begin
            r_bstate     <= w_bstate_nxt;
            r_btimer     <= w_btimer_nxt;
            r_beeps_left <= w_beeps_left_nxt;
        end
    end

    // Beep FSM next state; event pulses seen while a pattern plays are dropped
    always_comb begin
        w_bstate_nxt     = r_bstate;
        w_btimer_nxt     = r_btimer;
        w_beeps_left_nxt = r_beeps_left;
        case (r_bstate)
            B_IDLE: begin
                w_btimer_nxt = '0;
                if (r_short) begin
                    w_beeps_left_nxt = 2'd1;
                    w_bstate_nxt     = B_ON;
                end else if (r_long) begin
                    w_beeps_left_nxt = 2'd2;
                    w_bstate_nxt     = B_ON;
                end
            end
            B_ON: begin
                if (r_btimer == c_cnt_w'(c_beep_cyc - 1)) begin
                    w_btimer_nxt     = '0;
                    w_beeps_left_nxt = w_beeps_dec;
                    w_bstate_nxt     = (w_beeps_dec == 2'd0) ? B_IDLE : B_GAP;
                end else begin
                    w_btimer_nxt = r_btimer + c_cnt_w'(1);
                end
            end
            B_GAP: begin
                if (r_btimer == c_cnt_w'(c_gap_cyc - 1)) begin
                    w_btimer_nxt = '0;
                    w_bstate_nxt = B_ON;
                end else begin
                    w_btimer_nxt = r_btimer + c_cnt_w'(1);
                end
            end
            default: begin
                w_bstate_nxt     = B_IDLE;
                w_btimer_nxt     = '0;
                w_beeps_left_nxt = 2'd0;
            end
        endcase
    end

    assign w_beep_on = (r_bstate == B_ON);
    assign beep_busy = (r_bstate == B_ON) | (r_bstate == B_GAP);

`ifdef KEY_BEEP_TONE_EN
    logic w_tone;

    beep_tone_gen #(
        .TONE_HALF (TONE_HALF)
    ) u_tone (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .i_en    (w_beep_on),
        .o_tone  (w_tone)
    );

    assign beep = w_tone;
`else
    assign beep = w_beep_on;
`endif

endmodule : key_beep_ctrl

`default_nettype wire

// File: tb/tb_key_beep_ctrl.sv
// ============================================================================
//  Module      : tb_key_beep_ctrl
//  Description : Directed self-checking bench for key_beep_ctrl with small
//                timing parameters (1 kHz clock, 20/5/3 ms, tone half = 1).
//                Cycle N is the interval after the Nth rising edge; inputs
//                set during cycle N are sampled on edge N+1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_beep_ctrl;

    logic sys_clk   = 1'b0;
    logic rst_n     = 1'b0;
    logic key_flag  = 1'b0;
    logic key_value = 1'b1;
    logic short_press;
    logic long_press;
    logic beep;
    logic beep_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    key_beep_ctrl #(
        .CLK_FREQ  (1000),
        .LONG_MS   (20),
        .BEEP_MS   (5),
        .GAP_MS    (3),
        .TONE_HALF (1)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .key_flag    (key_flag),
        .key_value   (key_value),
        .short_press (short_press),
        .long_press  (long_press),
        .beep        (beep),
        .beep_busy   (beep_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    // Expected buzzer level at cycle c for a beep window starting at s
    function automatic logic exp_beep_at(int c, int s);
        if (s < 0 || c < s || c > s + 4) return 1'b0;
`ifdef KEY_BEEP_TONE_EN
        return ((c - s) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    // Runs cycles 10..c_end; p*/r* are press/release flag cycles (-1 = none),
    // s*/lg are expected pulse cycles, on1/on2 are expected beep window starts.
    task automatic scenario(input string tag, input int c_end,
                            input int p1, input int p2, input int r1, input int r2,
                            input int s1, input int s2, input int lg,
                            input int on1, input int on2);
        int busy_end;
        busy_end = (on2 >= 0) ? on2 + 4 : on1 + 4;
        cyc = 10;
        for (int c = 10; c <= c_end; c++) begin
            chk({tag, "_short"}, short_press, (c == s1) || (c == s2));
            chk({tag, "_long"},  long_press,  (c == lg));
            chk({tag, "_busy"},  beep_busy,   (on1 >= 0) && (c >= on1) && (c <= busy_end));
            chk({tag, "_beep"},  beep,        exp_beep_at(c, on1) | exp_beep_at(c, on2));
            key_flag = 1'b0;
            if (c == p1 || c == p2) begin
                key_flag  = 1'b1;
                key_value = 1'b0;
            end else if (c == r1 || c == r2) begin
                key_flag  = 1'b1;
                key_value = 1'b1;
            end
            step();
        end
        key_flag  = 1'b0;
        key_value = 1'b1;
    endtask

    initial begin
        // Reset held with key activity: everything stays quiet
        rst_n     = 1'b0;
        key_value = 1'b0;
        for (int i = 0; i < 3; i++) begin
            key_flag = ~key_flag;
            step();
            chk("rst_short", short_press, 1'b0);
            chk("rst_long",  long_press,  1'b0);
            chk("rst_beep",  beep,        1'b0);
            chk("rst_busy",  beep_busy,   1'b0);
        end
        key_flag  = 1'b0;
        key_value = 1'b1;
        rst_n     = 1'b1;
        step();
        step();

        // Reset in the middle of a beep aborts the pattern on the next edge
        cyc = 10;
        key_flag = 1'b1; key_value = 1'b0;
        step();                                   // 11
        key_flag = 1'b0;
        step();                                   // 12
        key_flag = 1'b1; key_value = 1'b1;
        step();                                   // 13
        key_flag = 1'b0;
        chk("mid_short", short_press, 1'b1);
        step();                                   // 14
        chk("mid_busy_on", beep_busy, 1'b1);
        chk("mid_beep_on", beep,      1'b1);
        step();                                   // 15
        chk("mid_busy_on2", beep_busy, 1'b1);
        rst_n = 1'b0;
        step();                                   // 16
        chk("mid_rst_beep",  beep,        1'b0);
        chk("mid_rst_busy",  beep_busy,   1'b0);
        chk("mid_rst_short", short_press, 1'b0);
        rst_n = 1'b1;
        step();                                   // 17
        chk("mid_after_busy", beep_busy, 1'b0);
        chk("mid_after_beep", beep,      1'b0);
        step();
        step();

        // Short press: flag 10, release 18
        scenario("short", 27, 10, -1, 18, -1, 19, -1, -1, 20, -1);
        // Long press: flag 10, release 40
        scenario("long",  46, 10, -1, 40, -1, -1, -1, 30, 31, 39);
        // Release on the threshold cycle: long only
        scenario("tie",   46, 10, -1, 29, -1, -1, -1, 30, 31, 39);
        // Second short press completes during the first beep: dropped
        scenario("drop",  27, 10, 20, 18, 21, 19, 22, -1, 20, -1);
        // Release in idle and a repeated press while held: no effect
        scenario("spur",  48, 12, 20, 10, 35, -1, -1, 32, 33, 41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_beep_ctrl

`default_nettype wire
